pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter IMG_W, default 256, pixels per line.
REQ-002 Parameter IMG_H, default 256, lines per frame.
REQ-003 Parameter GAP, default 16, idle cycles between strobes; legal range 2..255.
REQ-004 Parameter FRAMES, default 3, frames per run; legal range 1..255.
REQ-005 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-006 Port rstn, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, run request; sampled only in IDLE.
REQ-008 Port abort, input, 1, stop the run immediately.
REQ-009 Port mem_ren, output, 1, image RAM read enable; registered.
REQ-010 Port mem_addr, output, 16, pixel index; registered; equals line*IMG_W+col.
REQ-011 Port mem_rdata, input, 8, RAM data, valid exactly one cycle after mem_ren.
REQ-012 Port o_strb, output, 1, one-cycle pixel strobe; registered.
REQ-013 Port o_data, output, 8, pixel value; registered; valid only while o_strb=1.
REQ-014 Port busy, output, 1, high from the cycle after start is accepted until DONE.
REQ-015 Port done, output, 1, one-cycle pulse after the last pixel of the last frame.

Function
REQ-016 The FSM states SHALL be IDLE, FETCH, LOAD, EMIT, GAPW and DONE.
REQ-017 IDLE SHALL go to FETCH on start=1 and clear the pixel, line and frame counters.
REQ-018 FETCH SHALL assert mem_ren=1 with mem_addr set to the current index for exactly one cycle.
REQ-019 LOAD SHALL register o_data<=mem_rdata and o_strb<=1.
REQ-020 EMIT SHALL hold o_strb=1 for exactly one cycle, then advance the counters.
REQ-021 GAPW SHALL count GAP-2 cycles with o_strb=0, then return to FETCH.
REQ-022 Strobe period SHALL be exactly GAP+1 cycles, giving 17 with the defaults.
REQ-023 The first o_strb SHALL occur on the 3rd cycle after the edge that samples start.
REQ-024 The column SHALL wrap IMG_W-1->0 and increment the line; the line SHALL wrap IMG_H-1->0 and increment the frame.
REQ-025 mem_addr SHALL wrap to 0 at each new frame.
REQ-026 After pixel IMG_W*IMG_H-1 of frame FRAMES-1, EMIT SHALL go to DONE, skipping GAPW.
REQ-027 DONE SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-028 start=1 while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with o_strb=0, mem_ren=0, busy=0 and no done pulse.
REQ-030 abort and start high together in IDLE SHALL give priority to abort, so the run does not start.
REQ-031 The frame counter SHALL be 8 bits and the pixel index 16 bits; IMG_W*IMG_H SHALL be at most 65536.

Reset
REQ-032 rstn=0 SHALL force the following asynchronously: state=IDLE, all counters=0, mem_ren=0, mem_addr=0, o_strb=0, o_data=0, busy=0, done=0.
REQ-033 Reset asserted mid-frame SHALL discard the run; streaming SHALL resume only after a new start.

Configuration
REQ-034 Macro PIXEL_STREAMER_SYNC_EN, when defined, SHALL add outputs o_sof and o_eol; both are registered and 0 after reset.
REQ-035 With PIXEL_STREAMER_SYNC_EN defined, o_sof SHALL be 1 with the strobe of pixel 0 of each frame, and o_eol SHALL be 1 with the strobe of the last pixel of each line.
REQ-036 Without PIXEL_STREAMER_SYNC_EN, those ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Defaults, RAM[i]=i[7:0], one start: 196608 strobes, period 17; o_data sequence 0..255 repeated; a single done pulse; then busy=0.
REQ-038 IMG_W=4, IMG_H=2, FRAMES=1, GAP=2: first strobe 3 cycles after start; mem_addr 0..7; strobe period 3; done one cycle after the 8th strobe.
REQ-039 start pulsed again mid-run: strobe count and timing SHALL be unchanged from the single-start run.
REQ-040 abort raised after the 10th strobe: no further strobes, no done pulse, busy=0 on the next cycle; a following start restarts from mem_addr=0.
REQ-041 rstn pulled low for 2 cycles mid-frame: all outputs read 0 asynchronously; IDLE holds until a new start.
REQ-042 PIXEL_STREAMER_SYNC_EN defined, IMG_W=4, IMG_H=2, FRAMES=2: o_sof on strobes 1 and 9; o_eol on strobes 4, 8, 12 and 16.

Source files
------------

// File: rtl/pixel_streamer.sv
// Streams IMG_W x IMG_H pixels from an image RAM, FRAMES times, one strobe every GAP+1 cycles.
// Optional macro PIXEL_STREAMER_SYNC_EN adds o_sof/o_eol frame and line markers.
module pixel_streamer #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned GAP    = 16,
  parameter int unsigned FRAMES = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic        mem_ren,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        o_strb,
  output logic [7:0]  o_data,
  output logic        busy,
`ifdef PIXEL_STREAMER_SYNC_EN
  output logic        o_sof,
  output logic        o_eol,
`endif
  output logic        done
);

  localparam logic [15:0] ColLast   = 16'(IMG_W - 1);
  localparam logic [15:0] LineLast  = 16'(IMG_H - 1);
  localparam logic [7:0]  FrameLast = 8'(FRAMES - 1);
  localparam logic [7:0]  GapLast   = 8'(GAP - 3);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StEmit, StGapw, StDone} state_e;

  state_e      state_q;
  logic [15:0] col_q, line_q, pix_q;
  logic [7:0]  frame_q, gap_q;

  logic        col_end, line_end, last_pix;
  logic [15:0] pix_next;

  always_comb begin
    col_end  = (col_q == ColLast);
    line_end = (line_q == LineLast);
    last_pix = col_end && line_end && (frame_q == FrameLast);
    // The flat index restarts at 0 with every new frame.
    pix_next = (col_end && line_end) ? 16'd0 : pix_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      col_q    <= '0;
      line_q   <= '0;
      pix_q    <= '0;
      frame_q  <= '0;
      gap_q    <= '0;
      mem_ren  <= 1'b0;
      mem_addr <= '0;
      o_strb   <= 1'b0;
      o_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PIXEL_STREAMER_SYNC_EN
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
`endif
    end else if (abort && (state_q != StIdle)) begin
      state_q <= StIdle;
      mem_ren <= 1'b0;
      o_strb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PIXEL_STREAMER_SYNC_EN
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q  <= StFetch;
            col_q    <= '0;
            line_q   <= '0;
            pix_q    <= '0;
            frame_q  <= '0;
            mem_addr <= '0;
            mem_ren  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StFetch: begin
          mem_ren <= 1'b0;
          state_q <= StLoad;
        end
        StLoad: begin
          o_data  <= mem_rdata;
          o_strb  <= 1'b1;
`ifdef PIXEL_STREAMER_SYNC_EN
          o_sof   <= (pix_q == 16'd0);
          o_eol   <= col_end;
`endif
          state_q <= StEmit;
        end
        StEmit: begin
          o_strb <= 1'b0;
`ifdef PIXEL_STREAMER_SYNC_EN
          o_sof  <= 1'b0;
          o_eol  <= 1'b0;
`endif
          if (last_pix) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            pix_q <= pix_next;
            if (col_end) begin
              col_q <= '0;
              if (line_end) begin
                line_q  <= '0;
                frame_q <= frame_q + 8'd1;
              end else begin
                line_q <= line_q + 16'd1;
              end
            end else begin
              col_q <= col_q + 16'd1;
            end
            // With GAP=2 the wait phase is zero cycles long, so fetch right away.
            if (GAP > 2) begin
              state_q <= StGapw;
              gap_q   <= '0;
            end else begin
              state_q  <= StFetch;
              mem_ren  <= 1'b1;
              mem_addr <= pix_next;
            end
          end
        end
        StGapw: begin
          if (gap_q == GapLast) begin
            state_q  <= StFetch;
            mem_ren  <= 1'b1;
            mem_addr <= pix_q;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: two small configurations, table-driven scenarios plus random ones,
// checked cycle by cycle against strobe/fetch times derived from the period and start cycle.
module tb_pixel_streamer;

  localparam int NPIX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        start_s[2], abort_s[2], rstn_s[2];
  logic        ren_s[2], strb_s[2], busy_s[2], done_s[2];
  logic [15:0] addr_s[2];
  logic [7:0]  data_s[2], rdata_s[2];
  logic [7:0]  ram[2][NPIX];
`ifdef PIXEL_STREAMER_SYNC_EN
  logic        sof_s[2], eol_s[2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int w;
    int restart_at;
    bit abort_start;
    int abort_after;
    int rst_at;
    int exp_n;
    bit exp_done;
  } vec_t;

  vec_t tbl[10];

  pixel_streamer #(.IMG_W(4), .IMG_H(2), .GAP(2), .FRAMES(1)) dut_a (
`ifdef PIXEL_STREAMER_SYNC_EN
    .o_sof(sof_s[0]), .o_eol(eol_s[0]),
`endif
    .clk(clk), .rstn(rstn_s[0]), .start(start_s[0]), .abort(abort_s[0]),
    .mem_ren(ren_s[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
    .o_strb(strb_s[0]), .o_data(data_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  pixel_streamer #(.IMG_W(4), .IMG_H(2), .GAP(5), .FRAMES(2)) dut_b (
`ifdef PIXEL_STREAMER_SYNC_EN
    .o_sof(sof_s[1]), .o_eol(eol_s[1]),
`endif
    .clk(clk), .rstn(rstn_s[1]), .start(start_s[1]), .abort(abort_s[1]),
    .mem_ren(ren_s[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
    .o_strb(strb_s[1]), .o_data(data_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  // RAM returns the addressed byte only after a read; otherwise its complement.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      rdata_s[i] <= ren_s[i] ? ram[i][addr_s[i][2:0]] : ~ram[i][addr_s[i][2:0]];
  end

  function automatic int period(input int w);
    return (w == 0) ? 3 : 6;
  endfunction

  function automatic int total(input int w);
    return (w == 0) ? NPIX : 2 * NPIX;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_zero(input int w);
    chk("rst_mem_ren", ren_s[w], 0);
    chk("rst_mem_addr", addr_s[w], 0);
    chk("rst_o_strb", strb_s[w], 0);
    chk("rst_o_data", data_s[w], 0);
    chk("rst_busy", busy_s[w], 0);
    chk("rst_done", done_s[w], 0);
`ifdef PIXEL_STREAMER_SYNC_EN
    chk("rst_o_sof", sof_s[w], 0);
    chk("rst_o_eol", eol_s[w], 0);
`endif
  endtask

  task automatic run_case(input vec_t v);
    int w, p, tot, last_s, stop_c, k, lim;
    w      = v.w;
    p      = period(w);
    tot    = total(w);
    last_s = 3 + (tot - 1) * p;
    stop_c = v.abort_start ? 0 : 32'h4000_0000;
    k      = 0;
    lim    = last_s + 6;
    if (v.rst_at + 4 > lim) lim = v.rst_at + 4;
    for (int i = 0; i < NPIX; i++) ram[w][i] = 8'($urandom);
    @(negedge clk);
    start_s[w] = 1'b1;
    abort_s[w] = v.abort_start;
    for (int c = 1; c <= lim; c++) begin
      int  idx_s, idx_r;
      bit  e_strb, e_ren;
      @(negedge clk);
      e_strb = (c >= 3) && (c <= stop_c) && ((c - 3) % p == 0) && ((c - 3) / p < tot);
      e_ren  = (c <= stop_c) && ((c - 1) % p == 0) && ((c - 1) / p < tot);
      idx_s  = (c >= 3) ? (c - 3) / p : 0;
      idx_r  = (c - 1) / p;
      chk("o_strb", strb_s[w], e_strb);
      chk("mem_ren", ren_s[w], e_ren);
      chk("busy", busy_s[w], (c <= stop_c) && (c <= last_s));
      chk("done", done_s[w], (c == last_s + 1) && (c <= stop_c));
      if (strb_s[w]) k++;
      if (strb_s[w] && e_strb) begin
        chk("o_data", data_s[w], ram[w][idx_s % NPIX]);
`ifdef PIXEL_STREAMER_SYNC_EN
        chk("o_sof", sof_s[w], (idx_s % NPIX) == 0);
        chk("o_eol", eol_s[w], (idx_s % 4) == 3);
`endif
      end
      if (ren_s[w] && e_ren) chk("mem_addr", addr_s[w], idx_r % NPIX);
      start_s[w] = (c == v.restart_at);
      abort_s[w] = 1'b0;
      if (v.abort_after != 0 && strb_s[w] && k == v.abort_after) begin
        abort_s[w] = 1'b1;
        stop_c     = c;
      end
      if (v.rst_at != 0 && c == v.rst_at) begin
        rstn_s[w] = 1'b0;
        stop_c    = c;
        #1;
        check_zero(w);
      end
      if (v.rst_at != 0 && c == v.rst_at + 2) rstn_s[w] = 1'b1;
    end
    chk("strobe_count", k, v.exp_n);
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      rstn_s[i]  = 1'b1;
      for (int j = 0; j < NPIX; j++) ram[i][j] = 8'(j);
    end
    #2;
    rstn_s[0] = 1'b0;
    rstn_s[1] = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    repeat (2) @(negedge clk);
    rstn_s[0] = 1'b1;
    rstn_s[1] = 1'b1;

    //         w  restart abort+start abort_after rst_at exp_n done
    tbl[0] = '{0, 0,  1'b0, 0,  0,  8,  1'b1};
    tbl[1] = '{0, 10, 1'b0, 0,  0,  8,  1'b1};
    tbl[2] = '{0, 0,  1'b1, 0,  0,  0,  1'b0};
    tbl[3] = '{1, 0,  1'b0, 0,  0,  16, 1'b1};
    tbl[4] = '{1, 20, 1'b0, 0,  0,  16, 1'b1};
    tbl[5] = '{1, 0,  1'b0, 10, 0,  10, 1'b0};
    tbl[6] = '{1, 0,  1'b0, 0,  0,  16, 1'b1};
    tbl[7] = '{1, 0,  1'b0, 0,  28, 5,  1'b0};
    tbl[8] = '{0, 0,  1'b0, 0,  8,  2,  1'b0};
    tbl[9] = '{0, 0,  1'b0, 0,  0,  8,  1'b1};
    for (int i = 0; i < 10; i++) run_case(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      int mode;
      rv   = '{0, 0, 1'b0, 0, 0, 0, 1'b0};
      rv.w = int'($urandom_range(1, 0));
      mode = int'($urandom_range(2, 0));
      if (mode == 0) begin
        rv.restart_at = int'($urandom_range(20, 2));
        rv.exp_n      = total(rv.w);
        rv.exp_done   = 1'b1;
      end else if (mode == 1) begin
        rv.abort_after = int'($urandom_range(total(rv.w) - 1, 1));
        rv.exp_n       = rv.abort_after;
      end else begin
        rv.rst_at = int'($urandom_range(3 + (total(rv.w) - 2) * period(rv.w), 4));
        rv.exp_n  = (rv.rst_at - 3) / period(rv.w) + 1;
      end
      run_case(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
